corelet_ctrl: RTL
=================

// Module: corelet_ctrl
// PURPOSE
//  Instruction sequencer that drives the corelet inst[7:0] bus for one tile:
//  loads weights through L0 into the MAC array, streams activations, then
//  drains the OFIFO into psum memory. It owns the activation/weight SRAM read
//  port and the psum SRAM write port. Sits between the top-level testbench/host
//  start/done handshake and the corelet.
// PARAMETERS
//  row      8   MAC array rows (L0 vector count per weight tile)
//  col      8   MAC array columns (weight vectors loaded; OFIFO width)
//  addr_bw  11  SRAM address width
//  cnt_bw   8   width of num_x (activation vector count)
//  wgap     16  idle cycles after kernel load before execute (>= row+col)
//  tmo      255 drain watchdog limit in cycles (used only with CTRL_TIMEOUT_EN)
// PORTS
//  clk        in   1        clock
//  reset      in   1        synchronous, active-high
//  start      in   1        begin tile; sampled only in IDLE
//  num_x      in   cnt_bw   activation vectors in tile; sampled with start
//  w_base     in   addr_bw  SRAM address of first weight vector
//  x_base     in   addr_bw  SRAM address of first activation vector
//  ofifo_valid in  1        corelet OFIFO holds a full row
//  inst       out  8        corelet instruction bus
//  xw_mode    out  1        1 = L0 carries weights, 0 = activations
//  mem_cen    out  1        SRAM chip enable, active-low
//  mem_addr   out  addr_bw  SRAM read address
//  psum_wen   out  1        psum SRAM write enable, active-low
//  psum_addr  out  addr_bw  psum SRAM write address (starts at 0 per tile)
//  busy       out  1        high from accepted start until done
//  done       out  1        one-cycle pulse at tile completion
//  err        out  1        drain timeout sticky flag (0 if macro absent)
// BEHAVIOUR
//  inst map: [0] kernel load, [1] execute, [2] L0 wr, [3] L0 rd, [6] OFIFO rd,
//   [7] SFP valid; [5:4] and [7] driven 0 always. inst is registered.
//  Reset: state IDLE; inst=0, xw_mode=0, mem_cen=1, mem_addr=0, psum_wen=1,
//   psum_addr=0, busy=0, done=0, err=0; all counters 0.
//  SRAM read latency is 1 cycle: addr issued cycle t -> data on L0 input t+1,
//   so inst[2] is asserted exactly one cycle after the matching mem_cen=0.
//  FSM (cnt = phase counter, cleared on each state entry):
//   IDLE : start=1 -> latch num_x/bases, busy=1; num_x==0 -> DONE, else WFILL.
//   WFILL: xw_mode=1; cycles 0..col-1 mem_cen=0, mem_addr=w_base+cnt;
//          inst[2]=1 on cycles 1..col; after cycle col -> WLOAD.
//   WLOAD: xw_mode=1; inst[0]=inst[3]=1 for col cycles -> WGAP.
//   WGAP : inst=0 for wgap cycles -> XFILL.
//   XFILL: as WFILL with x_base and num_x vectors, xw_mode=0 -> XEXEC.
//   XEXEC: inst[1]=inst[3]=1 for num_x cycles -> DRAIN.
//   DRAIN: each cycle ofifo_valid=1 -> inst[6]=1; next cycle psum_wen=0 at
//          psum_addr, then psum_addr+1. After num_x reads and final write -> DONE.
//   DONE : done=1, busy=0 for one cycle -> IDLE.
//  Never assert inst[6] while ofifo_valid=0; never assert [0] and [1] together.
//  start while busy: ignored, latched values unchanged.
//  Reset mid-tile: next cycle is IDLE with reset values; no partial done.
//  psum_addr wraps modulo 2^addr_bw (no error).
// CONFIGURATION
//  CTRL_TIMEOUT_EN defined: DRAIN counts cycles with ofifo_valid=0 since last
//   read; reaching tmo sets err=1 (sticky until reset or next accepted start)
//   and forces DONE. Undefined: no watchdog, DRAIN waits indefinitely, err tied 0.
// TESTING
//  reset then start, num_x=4, w_base=0, x_base=16 -> mem_addr 0..7 then 16..19,
//   inst[2] pulses 8 then 4 cycles each lagging mem_cen by 1.
//  Same tile, ofifo_valid=1 from XEXEC end -> 4 inst[6] pulses, psum_addr 0..3
//   written, done pulse one cycle after last psum_wen=0, busy falls with done.
//  start with num_x=0 -> done 2 cycles after start, inst stays 0, mem_cen=1.
//  ofifo_valid toggled 1/0 in DRAIN -> inst[6] only in valid cycles, 4 writes total.
//  reset asserted during XEXEC -> next cycle inst=0, busy=0, state IDLE; new
//   start then completes normally.
//  CTRL_TIMEOUT_EN, ofifo_valid held 0 -> err=1 after tmo cycles, done pulses.

Source files
------------

// File: rtl/corelet_ctrl.sv
// Tile sequencer for the corelet: weight fill/load, activation fill/execute, OFIFO drain to psum SRAM.
// Optional drain watchdog enabled by defining CTRL_TIMEOUT_EN.
module corelet_ctrl #(
  parameter int row     = 8,
  parameter int col     = 8,
  parameter int addr_bw = 11,
  parameter int cnt_bw  = 8,
  parameter int wgap    = 16,
  parameter int tmo     = 255
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [cnt_bw-1:0]  num_x,
  input  logic [addr_bw-1:0] w_base,
  input  logic [addr_bw-1:0] x_base,
  input  logic               ofifo_valid,
  output logic [7:0]         inst,
  output logic               xw_mode,
  output logic               mem_cen,
  output logic [addr_bw-1:0] mem_addr,
  output logic               psum_wen,
  output logic [addr_bw-1:0] psum_addr,
  output logic               busy,
  output logic               done,
  output logic               err
);

  // Phase counter must cover fill length, gap, watchdog limit and the largest tile.
  localparam int M1 = (col + 1 > wgap) ? col + 1 : wgap;
  localparam int M2 = (M1 > tmo) ? M1 : tmo;
  localparam int M3 = (M2 > (1 << cnt_bw)) ? M2 : (1 << cnt_bw);
  localparam int M4 = (M3 > row) ? M3 : row;
  localparam int CW = $clog2(M4 + 1);

  localparam logic [CW-1:0] C_COL    = CW'(col);
  localparam logic [CW-1:0] C_COL_M1 = CW'(col - 1);
  localparam logic [CW-1:0] C_GAP_M1 = CW'(wgap - 1);

  localparam int I_KLOAD = 0;
  localparam int I_EXEC  = 1;
  localparam int I_L0WR  = 2;
  localparam int I_L0RD  = 3;
  localparam int I_ORD   = 6;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_WFILL = 3'd1;
  localparam logic [2:0] S_WLOAD = 3'd2;
  localparam logic [2:0] S_WGAP  = 3'd3;
  localparam logic [2:0] S_XFILL = 3'd4;
  localparam logic [2:0] S_XEXEC = 3'd5;
  localparam logic [2:0] S_DRAIN = 3'd6;
  localparam logic [2:0] S_DONE  = 3'd7;

  logic [2:0]         r_state;
  logic [CW-1:0]      r_cnt;
  logic [cnt_bw-1:0]  r_num;
  logic [cnt_bw-1:0]  r_rd;
  logic [addr_bw-1:0] r_w_base;
  logic [addr_bw-1:0] r_x_base;
  logic [7:0]         r_inst;
  logic               r_xw_mode;
  logic               r_mem_cen;
  logic [addr_bw-1:0] r_mem_addr;
  logic               r_psum_wen;
  logic [addr_bw-1:0] r_psum_addr;
  logic               r_busy;
  logic               r_done;

  logic [2:0]         w_state_nxt;
  logic [CW-1:0]      w_cnt_nxt;
  logic [CW-1:0]      w_num;
  logic [7:0]         w_inst_nxt;
  logic               w_xw_nxt;
  logic               w_cen_nxt;
  logic [addr_bw-1:0] w_addr_nxt;
  logic               w_busy_nxt;
  logic               w_done_nxt;
  logic               w_accept;
  logic               w_rd;
`ifdef CTRL_TIMEOUT_EN
  localparam logic [CW-1:0] C_TMO_M1 = CW'(tmo - 1);
  logic w_tmo_hit;
  logic r_err;
`endif

  assign w_num = CW'(r_num);

  // Outputs are registered from the current state, so every output trails its state by one cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_inst_nxt  = '0;
    w_xw_nxt    = 1'b0;
    w_cen_nxt   = 1'b1;
    w_addr_nxt  = r_mem_addr;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;
    w_accept    = 1'b0;
    w_rd        = 1'b0;
`ifdef CTRL_TIMEOUT_EN
    w_tmo_hit   = 1'b0;
`endif
    case (r_state)
      S_IDLE: begin
        w_busy_nxt = 1'b0;
        w_cnt_nxt  = '0;
        if (start) begin
          w_accept    = 1'b1;
          w_busy_nxt  = 1'b1;
          w_state_nxt = (num_x == '0) ? S_DONE : S_WFILL;
        end
      end
      S_WFILL: begin
        w_xw_nxt = 1'b1;
        if (r_cnt < C_COL) begin
          w_cen_nxt  = 1'b0;
          w_addr_nxt = r_w_base + addr_bw'(r_cnt);
        end
        w_inst_nxt[I_L0WR] = (r_cnt != '0);
        if (r_cnt == C_COL) begin
          w_state_nxt = S_WLOAD;
          w_cnt_nxt   = '0;
        end
      end
      S_WLOAD: begin
        w_xw_nxt            = 1'b1;
        w_inst_nxt[I_KLOAD] = 1'b1;
        w_inst_nxt[I_L0RD]  = 1'b1;
        if (r_cnt == C_COL_M1) begin
          w_state_nxt = S_WGAP;
          w_cnt_nxt   = '0;
        end
      end
      S_WGAP: begin
        if (r_cnt == C_GAP_M1) begin
          w_state_nxt = S_XFILL;
          w_cnt_nxt   = '0;
        end
      end
      S_XFILL: begin
        if (r_cnt < w_num) begin
          w_cen_nxt  = 1'b0;
          w_addr_nxt = r_x_base + addr_bw'(r_cnt);
        end
        w_inst_nxt[I_L0WR] = (r_cnt != '0);
        if (r_cnt == w_num) begin
          w_state_nxt = S_XEXEC;
          w_cnt_nxt   = '0;
        end
      end
      S_XEXEC: begin
        w_inst_nxt[I_EXEC] = 1'b1;
        w_inst_nxt[I_L0RD] = 1'b1;
        if (r_cnt == w_num - 1'b1) begin
          w_state_nxt = S_DRAIN;
          w_cnt_nxt   = '0;
        end
      end
      S_DRAIN: begin
        // Leaving once all reads are issued lets the last write land while DONE is registered.
        if (r_rd == r_num) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else if (ofifo_valid) begin
          w_rd              = 1'b1;
          w_inst_nxt[I_ORD] = 1'b1;
          w_cnt_nxt         = '0;
        end
`ifdef CTRL_TIMEOUT_EN
        else if (r_cnt == C_TMO_M1) begin
          w_tmo_hit   = 1'b1;
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end
`endif
      end
      S_DONE: begin
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_busy_nxt  = 1'b0;
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_num       <= '0;
      r_rd        <= '0;
      r_w_base    <= '0;
      r_x_base    <= '0;
      r_inst      <= '0;
      r_xw_mode   <= 1'b0;
      r_mem_cen   <= 1'b1;
      r_mem_addr  <= '0;
      r_psum_wen  <= 1'b1;
      r_psum_addr <= '0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_inst     <= w_inst_nxt;
      r_xw_mode  <= w_xw_nxt;
      r_mem_cen  <= w_cen_nxt;
      r_mem_addr <= w_addr_nxt;
      r_busy     <= w_busy_nxt;
      r_done     <= w_done_nxt;
      // Each OFIFO read is followed one cycle later by its psum write.
      r_psum_wen <= ~r_inst[I_ORD];
      if (w_accept) begin
        r_num       <= num_x;
        r_w_base    <= w_base;
        r_x_base    <= x_base;
        r_rd        <= '0;
        r_psum_addr <= '0;
      end else begin
        if (!r_psum_wen) r_psum_addr <= r_psum_addr + 1'b1;
        if (w_rd)        r_rd        <= r_rd + 1'b1;
      end
    end
  end

`ifdef CTRL_TIMEOUT_EN
  always_ff @(posedge clk) begin
    if (reset)          r_err <= 1'b0;
    else if (w_accept)  r_err <= 1'b0;
    else if (w_tmo_hit) r_err <= 1'b1;
  end
  assign err = r_err;
`else
  assign err = 1'b0;
`endif

  assign inst      = r_inst;
  assign xw_mode   = r_xw_mode;
  assign mem_cen   = r_mem_cen;
  assign mem_addr  = r_mem_addr;
  assign psum_wen  = r_psum_wen;
  assign psum_addr = r_psum_addr;
  assign busy      = r_busy;
  assign done      = r_done;

endmodule
